tb_pbus_merge: RTL and testbench
================================

Name: tb_pbus_merge

Overview:
- Two-manager to one-subordinate merger for the IOb native bus. It is the counterpart of the testbench peripheral-bus split.
- Lets two independent bus managers share one CSR port, e.g. a testbench driver and a second stimulus agent on one UART16550 instance.
- Arbitrates requests round-robin with per-request lock.
- Tracks outstanding reads in order so each read response returns to the manager that issued it.

Parameters:
- ADDR_W, 6, address width on all three ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- RD_DEPTH_W, 2, log2 of the maximum number of outstanding reads (default 4).

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; all registers update only when 1
- arst_n_i  in  1  reset, asynchronous, active-low
- s0_iob_valid_i  in  1  manager 0 request valid
- s0_iob_addr_i  in  ADDR_W  manager 0 address
- s0_iob_wdata_i  in  DATA_W  manager 0 write data
- s0_iob_wstrb_i  in  DATA_W/8  manager 0 byte strobes; all-zero means read
- s0_iob_rvalid_o  out  1  read data valid to manager 0
- s0_iob_rdata_o  out  DATA_W  read data to manager 0
- s0_iob_ready_o  out  1  request accepted from manager 0
- s1_iob_*  same set and directions as s0, for manager 1
- m_iob_valid_o  out  1  merged request valid
- m_iob_addr_o  out  ADDR_W  merged address
- m_iob_wdata_o  out  DATA_W  merged write data
- m_iob_wstrb_o  out  DATA_W/8  merged byte strobes
- m_iob_rvalid_i  in  1  subordinate read response valid
- m_iob_rdata_i  in  DATA_W  subordinate read data
- m_iob_ready_i  in  1  subordinate accepts request

Behaviour:
- Clock and reset: one clock, clk_i. Reset arst_n_i is asynchronous, active-low.
- Reset state: lock_q=0, gnt_q=0, last_q=1 (so manager 0 wins the first tie), ID FIFO empty.
- Outputs during reset: while arst_n_i=0, m_iob_valid_o, both sN_ready_o and both sN_rvalid_o are 0. All data outputs are 0.
- Definitions: a request is a read iff wstrb==0. Accept means m_iob_valid_o & m_iob_ready_i.
- Selection (combinational): sel = lock_q ? gnt_q : rr.
  - rr is the single valid requester if only one is valid.
  - If both are valid, rr = ~last_q.
  - If neither is valid, rr = ~last_q (don't-care).
- Forwarding: m_iob_valid_o = s[sel]_valid & ~(is_read & fifo_full). Address, data and strobes mux from s[sel].
  - Zero added latency on the request path.
- Ready routing: s[sel]_ready_o = m_iob_ready_i & m_iob_valid_o. The other ready_o is 0.
- Lock:
  - If m_iob_valid_o=1 and m_iob_ready_i=0: lock_q<=1, gnt_q<=sel.
  - On accept: lock_q<=0, last_q<=sel.
  - A locked grant never moves to the other manager until accepted. Managers hold valid and fields stable until ready (IOb rule).
- Reads are stalled when the FIFO is full; writes are not:
  - A read request with the FIFO full is stalled: m_iob_valid_o=0, and the lock is still taken so fairness holds.
  - Writes proceed regardless of FIFO state.
- ID FIFO: depth 2^RD_DEPTH_W, entries are 1-bit source IDs.
  - Push sel on accept of a read. Pop on m_iob_rvalid_i.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - full = (count == depth). A push is blocked when full even if a pop occurs the same cycle.
- Response routing (combinational):
  - s[head]_rvalid_o = m_iob_rvalid_i and s[head]_rdata_o = m_iob_rdata_i.
  - The non-target gets rvalid 0 and rdata 0.
- Spurious response: m_iob_rvalid_i with the FIFO empty is dropped, with no pop and no rvalid out. A simulation-only assertion fires.
- Clock enable: with cke_i=0 all registers hold. The design assumes the whole subsystem shares cke_i, so no handshakes occur while it is low.
- Reset mid-operation: reset aborts any lock and discards outstanding IDs. Late rvalid after reset is a spurious response.

Decomposition:
- Shared package/header holds:
  - the source-ID width constant (1);
  - the read-detect macro (wstrb==0);
  - the reset values of lock_q, gnt_q and last_q.
- One sub-module, tb_pbus_merge_id_fifo: a register-based synchronous FIFO.
  - Ports: push/pop/din/dout/full/empty/count.
  - Same clk_i/cke_i/arst_n_i.
  - Parameter RD_DEPTH_W.

Test Plan:
- Solo traffic: s0 writes addr 0x03 data 0xA5 with wstrb 0xF, ready tied 1. m sees 0x03/0xA5 the same cycle, s0_ready=1, s1_ready=0, no rvalid anywhere.
- Tie: s0 and s1 are both valid every cycle for 4 accepts, ready=1. Grant order is s0,s1,s0,s1.
- Lock: s1 is granted with ready=0 for 3 cycles while s0 asserts valid. m addr stays s1's until ready=1; s0 is granted next.
- Read routing: s0 reads 0x04, then s1 reads 0x08; subordinate returns rvalid with 0x11 then 0x22. s0 gets 0x11 and s1 gets 0x22; no rvalid leaks to the other manager.
- FIFO full: 4 reads are accepted with no response and a 5th read is presented. m_iob_valid_o=0 until one rvalid pops; the 5th is then accepted. A write from the other manager passes during the stall.
- Reset: arst_n_i is pulsed low while lock_q=1 and 2 reads are outstanding. All outputs go to 0 immediately. After release, count=0 and s0 wins the first tie.

Source files
------------

// File: rtl/tb_pbus_merge_pkg.sv
// Shared definitions for the two-manager IOb merger: source-ID width,
// read detection and the arbiter reset values.
package tb_pbus_merge_pkg;

    localparam int ID_W       = 1;
    localparam int MAX_STRB_W = 64;

    typedef logic [ID_W-1:0] src_id_t;

    localparam logic    LOCK_RST = 1'b0;
    localparam src_id_t GNT_RST  = src_id_t'(0);
    // last_q starts at 1 so that manager 0 wins the first tie.
    localparam src_id_t LAST_RST = src_id_t'(1);

    // An IOb request with no byte strobes set is a read.
    function automatic logic is_read(input logic [MAX_STRB_W-1:0] wstrb);
        return wstrb == '0;
    endfunction

endpackage

// File: rtl/tb_pbus_merge_id_fifo.sv
// Register-based FIFO of read source IDs, kept in issue order so each
// read response can be steered back to the manager that asked for it.
module tb_pbus_merge_id_fifo
    import tb_pbus_merge_pkg::*;
#(
    parameter int RD_DEPTH_W = 2
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,
    input  logic                push,
    input  logic                pop,
    input  src_id_t             din,
    output src_id_t             dout,
    output logic                full,
    output logic                empty,
    output logic [RD_DEPTH_W:0] count
);

    localparam int DEPTH = 1 << RD_DEPTH_W;

    src_id_t                mem_q [DEPTH];
    logic [RD_DEPTH_W-1:0]  wr_ptr_q;
    logic [RD_DEPTH_W-1:0]  rd_ptr_q;
    logic [RD_DEPTH_W:0]    count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count_q == (RD_DEPTH_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A pop in the same cycle does not free room for a push when full.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cke_i) begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + RD_DEPTH_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + RD_DEPTH_W'(1);
            end
            count_q <= count_q + {{RD_DEPTH_W{1'b0}}, do_push}
                               - {{RD_DEPTH_W{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/tb_pbus_merge.sv
// Two-manager to one-subordinate IOb merger: round-robin arbitration with a
// per-request lock, zero-latency request path, in-order read response routing.
module tb_pbus_merge
    import tb_pbus_merge_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int RD_DEPTH_W = 2
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_n_i,

    input  logic                s0_iob_valid_i,
    input  logic [ADDR_W-1:0]   s0_iob_addr_i,
    input  logic [DATA_W-1:0]   s0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s0_iob_wstrb_i,
    output logic                s0_iob_rvalid_o,
    output logic [DATA_W-1:0]   s0_iob_rdata_o,
    output logic                s0_iob_ready_o,

    input  logic                s1_iob_valid_i,
    input  logic [ADDR_W-1:0]   s1_iob_addr_i,
    input  logic [DATA_W-1:0]   s1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s1_iob_wstrb_i,
    output logic                s1_iob_rvalid_o,
    output logic [DATA_W-1:0]   s1_iob_rdata_o,
    output logic                s1_iob_ready_o,

    output logic                m_iob_valid_o,
    output logic [ADDR_W-1:0]   m_iob_addr_o,
    output logic [DATA_W-1:0]   m_iob_wdata_o,
    output logic [DATA_W/8-1:0] m_iob_wstrb_o,
    input  logic                m_iob_rvalid_i,
    input  logic [DATA_W-1:0]   m_iob_rdata_i,
    input  logic                m_iob_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]        s_valid;
    logic [ADDR_W-1:0] s_addr  [2];
    logic [DATA_W-1:0] s_wdata [2];
    logic [STRB_W-1:0] s_wstrb [2];
    logic [1:0]        s_ready;
    logic [1:0]        s_rvalid;
    logic [DATA_W-1:0] s_rdata [2];

    logic    lock_q;
    src_id_t gnt_q;
    src_id_t last_q;
    src_id_t rr;
    src_id_t sel;
    logic    sel_read;
    logic    fwd_valid;
    logic    accept;
    logic    rsp_route;

    src_id_t             fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [RD_DEPTH_W:0] fifo_count;

    assign s_valid    = {s1_iob_valid_i, s0_iob_valid_i};
    assign s_addr[0]  = s0_iob_addr_i;
    assign s_addr[1]  = s1_iob_addr_i;
    assign s_wdata[0] = s0_iob_wdata_i;
    assign s_wdata[1] = s1_iob_wdata_i;
    assign s_wstrb[0] = s0_iob_wstrb_i;
    assign s_wstrb[1] = s1_iob_wstrb_i;

    always_comb begin
        rr = ~last_q;
        case (s_valid)
            2'b01:   rr = src_id_t'(0);
            2'b10:   rr = src_id_t'(1);
            default: rr = ~last_q;
        endcase
    end

    assign sel       = lock_q ? gnt_q : rr;
    assign sel_read  = is_read(MAX_STRB_W'(s_wstrb[sel]));
    assign fwd_valid = s_valid[sel] & ~(sel_read & fifo_full);
    assign accept    = fwd_valid & m_iob_ready_i;

    // Outputs are forced to zero while reset is asserted, not just after it.
    assign m_iob_valid_o = fwd_valid & arst_n_i;
    assign m_iob_addr_o  = arst_n_i ? s_addr[sel]  : '0;
    assign m_iob_wdata_o = arst_n_i ? s_wdata[sel] : '0;
    assign m_iob_wstrb_o = arst_n_i ? s_wstrb[sel] : '0;

    assign rsp_route = arst_n_i & ~fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mgr
            assign s_ready[gi]  = arst_n_i & accept & (sel == src_id_t'(gi));
            assign s_rvalid[gi] = rsp_route & m_iob_rvalid_i
                                  & (fifo_head == src_id_t'(gi));
            assign s_rdata[gi]  = (rsp_route && fifo_head == src_id_t'(gi))
                                  ? m_iob_rdata_i : '0;
        end
    endgenerate

    assign s0_iob_ready_o  = s_ready[0];
    assign s1_iob_ready_o  = s_ready[1];
    assign s0_iob_rvalid_o = s_rvalid[0];
    assign s1_iob_rvalid_o = s_rvalid[1];
    assign s0_iob_rdata_o  = s_rdata[0];
    assign s1_iob_rdata_o  = s_rdata[1];

    // A stalled full-FIFO read also takes the lock, so the other manager
    // cannot overtake it while it waits for a response to drain.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            lock_q <= LOCK_RST;
            gnt_q  <= GNT_RST;
            last_q <= LAST_RST;
        end else if (cke_i) begin
            if (accept) begin
                lock_q <= 1'b0;
                last_q <= sel;
            end else if (s_valid[sel]) begin
                lock_q <= 1'b1;
                gnt_q  <= sel;
            end
        end
    end

    tb_pbus_merge_id_fifo #(
        .RD_DEPTH_W(RD_DEPTH_W)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .cke_i    (cke_i),
        .arst_n_i (arst_n_i),
        .push     (accept & sel_read),
        .pop      (m_iob_rvalid_i),
        .din      (sel),
        .dout     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // A response with no read outstanding is dropped.
    spurious_rsp: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        (cke_i && m_iob_rvalid_i) |-> (fifo_count != '0));

endmodule

// File: tb/tb_tb_pbus_merge.sv
// Bench for tb_pbus_merge: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_tb_pbus_merge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst_n = 1'b0;
    logic [1:0]  sv = '0;
    logic [5:0]  sa [2];
    logic [31:0] sd [2];
    logic [3:0]  ws [2];
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    logic        s0_ready, s1_ready, s0_rvalid, s1_rvalid;
    logic [31:0] s0_rdata, s1_rdata;
    logic        m_valid;
    logic [5:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;

    wire [1:0] srdy = {s1_ready, s0_ready};
    wire [1:0] srv  = {s1_rvalid, s0_rvalid};

    int n_chk  = 0;
    int n_fail = 0;

    // model state: lock owner, last winner, read IDs in issue order
    bit m_lock;
    int m_owner;
    int m_last;
    int q[$];

    always #5 clk = ~clk;

    tb_pbus_merge dut (
        .clk_i           (clk),
        .cke_i           (cke),
        .arst_n_i        (arst_n),
        .s0_iob_valid_i  (sv[0]),
        .s0_iob_addr_i   (sa[0]),
        .s0_iob_wdata_i  (sd[0]),
        .s0_iob_wstrb_i  (ws[0]),
        .s0_iob_rvalid_o (s0_rvalid),
        .s0_iob_rdata_o  (s0_rdata),
        .s0_iob_ready_o  (s0_ready),
        .s1_iob_valid_i  (sv[1]),
        .s1_iob_addr_i   (sa[1]),
        .s1_iob_wdata_i  (sd[1]),
        .s1_iob_wstrb_i  (ws[1]),
        .s1_iob_rvalid_o (s1_rvalid),
        .s1_iob_rdata_o  (s1_rdata),
        .s1_iob_ready_o  (s1_ready),
        .m_iob_valid_o   (m_valid),
        .m_iob_addr_o    (m_addr),
        .m_iob_wdata_o   (m_wdata),
        .m_iob_wstrb_o   (m_wstrb),
        .m_iob_rvalid_i  (m_rvalid),
        .m_iob_rdata_i   (m_rdata),
        .m_iob_ready_i   (m_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sv = '0;
        m_ready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            sa[i] = '0;
            sd[i] = '0;
            ws[i] = '0;
        end
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model; inputs are stable here.
    always @(negedge clk) begin
        int cand;
        bit rd, ev;
        logic [1:0]  e_rdy, e_rv;
        logic [31:0] e_rd0, e_rd1;
        if (!arst_n) begin
            m_lock = 1'b0;
            m_owner = 0;
            m_last = 1;
            q.delete();
            chk("rst_ctl", {m_valid, srdy, srv, m_addr, m_wstrb}, 64'd0);
            chk("rst_wdata", m_wdata, 64'd0);
            chk("rst_rdata", {s0_rdata, s1_rdata}, 64'd0);
        end else begin
            if (m_lock)          cand = m_owner;
            else if (sv == 2'b01) cand = 0;
            else if (sv == 2'b10) cand = 1;
            else                  cand = (m_last == 1) ? 0 : 1;
            rd = (ws[cand] == 4'h0);
            ev = sv[cand] && !(rd && q.size() == DEPTH);
            chk("m_valid", m_valid, ev);
            if (ev) begin
                chk("m_addr", m_addr, sa[cand]);
                chk("m_wdata", m_wdata, sd[cand]);
                chk("m_wstrb", m_wstrb, ws[cand]);
            end
            e_rdy = (ev && m_ready) ? (2'b01 << cand) : 2'b00;
            chk("s_ready", srdy, e_rdy);
            e_rv = 2'b00;
            e_rd0 = '0;
            e_rd1 = '0;
            if (q.size() > 0) begin
                if (q[0] == 0) e_rd0 = m_rdata;
                else           e_rd1 = m_rdata;
                if (m_rvalid) e_rv = (q[0] == 0) ? 2'b01 : 2'b10;
            end
            chk("s_rvalid", srv, e_rv);
            chk("s0_rdata", s0_rdata, e_rd0);
            chk("s1_rdata", s1_rdata, e_rd1);
            if (ev && m_ready) begin
                m_lock = 1'b0;
                m_last = cand;
            end else if (sv[cand]) begin
                m_lock = 1'b1;
                m_owner = cand;
            end
            if (m_rvalid && q.size() > 0) void'(q.pop_front());
            if (ev && m_ready && rd) q.push_back(cand);
        end
    end

    initial begin
        int sub_out;
        bit [1:0] done;
        idle();
        do_reset();

        // solo write
        sv[0] = 1'b1; sa[0] = 6'h03; sd[0] = 32'hA5; ws[0] = 4'hF; m_ready = 1'b1;
        #1;
        chk("solo_addr", m_addr, 64'h03);
        chk("solo_wdata", m_wdata, 64'hA5);
        chk("solo_ready", srdy, 64'b01);
        chk("solo_rvalid", srv, 64'b00);
        step();

        // tie: alternating grants starting with s0
        do_reset();
        sv = 2'b11; sa[0] = 6'h01; sa[1] = 6'h02; ws[0] = 4'hF; ws[1] = 4'hF; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_grant", srdy, (i % 2) ? 64'b10 : 64'b01);
            step();
        end

        // lock held by s1 through three stalled cycles
        do_reset();
        sv[1] = 1'b1; sa[1] = 6'h2A; ws[1] = 4'hF; m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                sv[0] = 1'b1; sa[0] = 6'h15; ws[0] = 4'hF;
            end
            #1;
            chk("lock_addr", m_addr, 64'h2A);
            chk("lock_ready", srdy, 64'b00);
            step();
        end
        m_ready = 1'b1;
        #1;
        chk("lock_release", srdy, 64'b10);
        step();
        sa[1] = 6'h2B;
        #1;
        chk("lock_next", srdy, 64'b01);
        chk("lock_next_addr", m_addr, 64'h15);
        step();

        // read routing
        do_reset();
        m_ready = 1'b1;
        sv[0] = 1'b1; sa[0] = 6'h04; ws[0] = 4'h0;
        #1; chk("rd_s0_acc", srdy, 64'b01); step();
        sv[0] = 1'b0; sv[1] = 1'b1; sa[1] = 6'h08; ws[1] = 4'h0;
        #1; chk("rd_s1_acc", srdy, 64'b10); step();
        sv[1] = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11;
        #1;
        chk("rsp0_rvalid", srv, 64'b01);
        chk("rsp0_data", s0_rdata, 64'h11);
        chk("rsp0_other", s1_rdata, 64'h0);
        step();
        m_rdata = 32'h22;
        #1;
        chk("rsp1_rvalid", srv, 64'b10);
        chk("rsp1_data", s1_rdata, 64'h22);
        chk("rsp1_other", s0_rdata, 64'h0);
        step();
        idle();

        // FIFO full: write passes, read stalls until a pop
        do_reset();
        m_ready = 1'b1; sv[0] = 1'b1; ws[0] = 4'h0;
        for (int i = 0; i < 4; i++) begin
            sa[0] = 6'(i);
            #1; chk("full_fill", srdy, 64'b01); step();
        end
        sa[0] = 6'h09; sv[1] = 1'b1; sa[1] = 6'h30; ws[1] = 4'hF;
        #1;
        chk("full_wr_pass", srdy, 64'b10);
        chk("full_wr_addr", m_addr, 64'h30);
        step();
        sv[1] = 1'b0;
        #1; chk("full_stall", m_valid, 64'd0); step();
        m_rvalid = 1'b1; m_rdata = 32'h5;
        #1;
        chk("full_pop_rvalid", srv, 64'b01);
        chk("full_stall_pop", m_valid, 64'd0);
        step();
        m_rvalid = 1'b0;
        #1;
        chk("full_resume", srdy, 64'b01);
        chk("full_resume_addr", m_addr, 64'h09);
        step();

        // randomized traffic
        do_reset();
        sub_out = 0;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) done[i] = sv[i] & srdy[i];
            if (m_valid && m_ready && m_wstrb == 4'h0) sub_out++;
            if (m_rvalid) sub_out--;
            step();
            for (int i = 0; i < 2; i++) begin
                if (!sv[i] || done[i]) begin
                    sv[i] = ($urandom_range(0, 99) < 60);
                    sa[i] = 6'($urandom);
                    sd[i] = $urandom;
                    ws[i] = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                end
            end
            m_ready  = ($urandom_range(0, 99) < 70);
            m_rvalid = (sub_out > 0) && ($urandom_range(0, 99) < 40);
            m_rdata  = $urandom;
        end

        // reset while locked with two reads outstanding
        do_reset();
        m_ready = 1'b1; sv = 2'b11; sa[0] = 6'h01; sa[1] = 6'h02; ws[0] = 4'h0; ws[1] = 4'h0;
        step();
        step();
        sv = 2'b01; ws[0] = 4'hF; sa[0] = 6'h03; sd[0] = 32'hDEAD; m_ready = 1'b0;
        step();
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 64'd0);
        chk("arst_ready", srdy, 64'b00);
        chk("arst_addr", m_addr, 64'h0);
        chk("arst_wdata", m_wdata, 64'h0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        sv = 2'b11; ws[0] = 4'h0; ws[1] = 4'h0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("post_rst_grant", srdy, (i % 2) ? 64'b10 : 64'b01); step();
        end
        #1; chk("post_rst_full", m_valid, 64'd0);
        step();
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
